// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU, single-cycle logic/arith ops plus iterative mul/divu/remu with valid/ready handshake
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, out_q, out_d;
    logic zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
    logic [WIDTH:0] sum, dif, rsh;
    logic [WIDTH-1:0] res, st_a, st_b, st_acc, fin;
    logic res_c, res_v, res_e, ge, mul_st;

    always_comb begin
        sum = {1'b0, in1} + {1'b0, in2};
        dif = {1'b0, in1} + {1'b0, ~in2} + 1'b1;
        res = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_e = 1'b0;
        case (op)
            4'h0: begin
                res = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            4'h1: begin
                res = dif[WIDTH-1:0];
                res_c = dif[WIDTH];
                res_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
            end
            4'h2: res = in1 & in2;
            4'h3: res = in1 | in2;
            4'h4: res = in1 ^ in2;
            4'h5: res = in1 << in2[SW-1:0];
            4'h6: res = in1 >> in2[SW-1:0];
            4'h7: res = WIDTH'($signed(in1) >>> in2[SW-1:0]);
            4'h8: res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            4'h9: res = {{(WIDTH-1){1'b0}}, in1 < in2};
            default: res_e = 1'b1;
        endcase
    end

    // one iteration: shift-add for mul, restoring shift-subtract for div/rem (a_q holds dividend/quotient, acc_q remainder)
    always_comb begin
        rsh = {acc_q, a_q[WIDTH-1]};
        ge = rsh >= {1'b0, b_q};
        mul_st = op_q == 4'hA;
        st_acc = mul_st ? acc_q + (b_q[0] ? a_q : '0) : ge ? rsh[WIDTH-1:0] - b_q : rsh[WIDTH-1:0];
        st_a = mul_st ? a_q << 1 : {a_q[WIDTH-2:0], ge};
        st_b = mul_st ? b_q >> 1 : b_q;
        fin = op_q == 4'hB ? st_a : st_acc;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        out_d = out_q;
        zero_d = zero_q;
        carry_d = carry_q;
        ovf_d = ovf_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = op;
                if (op >= 4'hA && op <= 4'hC) begin
                    state_d = BUSY;
                    cnt_d = CW'(WIDTH);
                    a_d = in1;
                    b_d = in2;
                    acc_d = '0;
                end else begin
                    state_d = DONE;
                    out_d = res;
                    zero_d = res == '0;
                    carry_d = res_c;
                    ovf_d = res_v;
                    err_d = res_e;
                end
            end
            BUSY: begin
                a_d = st_a;
                b_d = st_b;
                acc_d = st_acc;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    out_d = fin;
                    zero_d = fin == '0;
                    carry_d = 1'b0;
                    ovf_d = 1'b0;
                    err_d = !mul_st && b_q == '0;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            out_q <= '0;
            zero_q <= 1'b0;
            carry_q <= 1'b0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            out_q <= out_d;
            zero_q <= zero_d;
            carry_q <= carry_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out = out_q;
    assign zero = zero_q;
    assign carry = carry_q;
    assign ovf = ovf_q;
    assign err = err_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc (WIDTH 32 and 8) against a behavioural model
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic iv = 1'b0, ordy = 1'b0, ir, ov, z, c, v, e;
    logic [3:0] op = '0;
    logic [31:0] a = '0, b = '0, o;
    logic iv8 = 1'b0, ordy8 = 1'b0, ir8, ov8, z8, c8, v8, e8;
    logic [3:0] op8 = '0;
    logic [7:0] a8 = '0, b8 = '0, o8;
    int n_pass = 0, n_chk = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .op(op), .in1(a), .in2(b),
        .out_valid(ov), .out_ready(ordy), .out(o), .zero(z), .carry(c), .ovf(v), .err(e)
    );
    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .in1(a8), .in2(b8),
        .out_valid(ov8), .out_ready(ordy8), .out(o8), .zero(z8), .carry(c8), .ovf(v8), .err(e8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // reference: results from plain integer arithmetic on the operand values
    function automatic void model(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic fz, output logic fc,
                                  output logic fv, output logic fe);
        longint sx, sy, s;
        logic [63:0] w;
        sx = $signed(x);
        sy = $signed(y);
        r = '0; fc = 1'b0; fv = 1'b0; fe = 1'b0;
        case (f)
            4'h0: begin
                w = {32'b0, x} + {32'b0, y}; r = w[31:0]; fc = w[32];
                s = sx + sy; fv = s != longint'($signed(r));
            end
            4'h1: begin
                r = x - y; fc = x >= y;
                s = sx - sy; fv = s != longint'($signed(r));
            end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h5: r = x << y[4:0];
            4'h6: r = x >> y[4:0];
            4'h7: r = $signed(x) >>> y[4:0];
            4'h8: r = (sx < sy) ? 32'd1 : 32'd0;
            4'h9: r = (x < y) ? 32'd1 : 32'd0;
            4'hA: begin w = {32'b0, x} * {32'b0, y}; r = w[31:0]; end
            4'hB: if (y == 0) begin r = '1; fe = 1'b1; end else r = x / y;
            4'hC: if (y == 0) begin r = x; fe = 1'b1; end else r = x % y;
            default: fe = 1'b1;
        endcase
        fz = r == 0;
    endfunction

    task automatic start(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        @(negedge clk);
        iv = 1'b1; op = f; a = x; b = y;
        while (!ir && n < 100) begin @(negedge clk); n++; end
        chk("accept ready", 64'(ir), 64'(1));
        @(posedge clk);
        #1 iv = 1'b0;
    endtask

    task automatic finish(input string tag, input logic [31:0] eo, input logic ez, input logic ec,
                          input logic ev, input logic ee, input int elat, input int hold);
        int n = 0;
        logic bad = 1'b0;
        do begin @(negedge clk); n++; if (ir) bad = 1'b1; end while (!ov && n < 100);
        chk({tag, " latency"}, 64'(n), 64'(elat));
        chk({tag, " in_ready low"}, 64'(bad), 64'(0));
        chk({tag, " out"}, 64'(o), 64'(eo));
        chk({tag, " flags zcve"}, 64'({z, c, v, e}), 64'({ez, ec, ev, ee}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold"}, 64'({ov, o, z, c, v, e}), 64'({1'b1, eo, ez, ec, ev, ee}));
        end
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        @(negedge clk);
        chk({tag, " released"}, 64'({ov, ir}), 64'(2'b01));
    endtask

    task automatic run8(input string tag, input logic [3:0] f, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] eo, input logic ez, input logic ee, input int elat);
        int n = 0;
        @(negedge clk);
        iv8 = 1'b1; op8 = f; a8 = x; b8 = y;
        chk({tag, " ready"}, 64'(ir8), 64'(1));
        @(posedge clk);
        #1 iv8 = 1'b0;
        do begin @(negedge clk); n++; end while (!ov8 && n < 100);
        chk({tag, " latency"}, 64'(n), 64'(elat));
        chk({tag, " out/zero/err"}, 64'({o8, z8, e8}), 64'({eo, ez, ee}));
        ordy8 = 1'b1;
        @(posedge clk);
        #1 ordy8 = 1'b0;
    endtask

    initial begin
        logic [31:0] r, x, y;
        logic fz, fc, fv, fe;
        logic [3:0] f;
        logic bad;
        #2 rst_n = 1'b0;
        #1;
        chk("reset outputs", 64'({ov, o, z, c, v, e}), 64'(0));
        chk("reset ready", 64'({ir, ir8, ov8}), 64'(3'b110));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", 64'(ir), 64'(1));

        start(4'h0, 32'h7FFF_FFFF, 32'h1);
        finish("add ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        start(4'h1, 32'd5, 32'd5);
        finish("sub eq", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
        start(4'h1, 32'h0, 32'h1);
        finish("sub borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        start(4'h1, 32'h8000_0000, 32'h1);
        finish("sub ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
        start(4'h0, 32'hFFFF_FFFF, 32'h1);
        finish("add carry", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
        start(4'h8, 32'hFFFF_FFFF, 32'h1);
        finish("slt", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        start(4'h9, 32'hFFFF_FFFF, 32'h1);
        finish("sltu", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        start(4'hF, 32'h1234, 32'h5678);
        finish("illegal", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);

        start(4'hA, 32'h0000_FFFF, 32'h0001_0001);
        @(negedge clk);
        iv = 1'b1; op = 4'h0; a = 32'd2; b = 32'd3;
        finish("mul", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32, 2);
        @(posedge clk);
        #1 iv = 1'b0;
        finish("stalled add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

        start(4'hB, 32'd100, 32'd7);
        finish("divu", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0, 33, 0);
        start(4'hC, 32'd100, 32'd7);
        finish("remu", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33, 0);
        start(4'hB, 32'd9, 32'd0);
        finish("divu by 0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 33, 0);
        start(4'hC, 32'd9, 32'd0);
        finish("remu by 0", 32'd9, 1'b0, 1'b0, 1'b0, 1'b1, 33, 0);
        start(4'h7, 32'h8000_0000, 32'd4);
        finish("sra hold", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 5);

        start(4'hB, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-div reset outputs", 64'({ov, o, z, c, v, e}), 64'(0));
        chk("mid-div reset ready", 64'(ir), 64'(1));
        #1 rst_n = 1'b1;
        bad = 1'b0;
        repeat (40) begin @(negedge clk); if (ov) bad = 1'b1; end
        chk("aborted op silent", 64'(bad), 64'(0));
        start(4'h0, 32'd2, 32'd3);
        finish("add after reset", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

        run8("w8 illegal", 4'hE, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 1);
        run8("w8 mul", 4'hA, 8'd16, 8'd16, 8'h00, 1'b1, 1'b0, 9);
        run8("w8 divu", 4'hB, 8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 9);

        for (int i = 0; i < 40; i++) begin
            f = 4'($urandom_range(0, 15));
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            model(f, x, y, r, fz, fc, fv, fe);
            start(f, x, y);
            finish($sformatf("rnd op%0h", f), r, fz, fc, fv, fe,
                   (f >= 4'hA && f <= 4'hC) ? 33 : 1, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
